// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types and width helpers for the FIFO drain stage
// Contents: WORDS_SENT_W, occ_t (buffer occupancy 0..2), beat_w() beat-counter width.
package fifo_stream_pkg;

  localparam int WORDS_SENT_W = 16;

  typedef logic [1:0] occ_t;

  // Width of a counter that spans 0..burst_len-1; never narrower than one bit.
  function automatic int beat_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - two-entry in-order register buffer
// Ports: clk, reset (async, active-high), push_i/push_data_i write the tail,
//        pop_i removes the head, head_o is the oldest word, occ_o is 0..2 entries.
module stream_buf2
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output occ_t             occ_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  occ_t             occ_q, occ_d;

  // The caller never pops an empty buffer nor pushes a full one without a pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves and the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a synchronous FIFO onto a valid/ready burst stream
// Ports: clk, reset (async, active-high), enable gates new reads; FIFO side fifo_empty,
//        fifo_rd, fifo_rdata (one-cycle read latency); stream side m_valid, m_ready,
//        m_data, m_last (last beat of each BURST_LEN burst); words_sent handshake count.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [WIDTH-1:0]        fifo_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_last,
  output logic [WORDS_SENT_W-1:0] words_sent
);

  localparam int                BEAT_W   = beat_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  occ_t                    occ;
  occ_t                    occ_sum;
  logic                    inflight_q;
  logic                    pop;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [WORDS_SENT_W-1:0] words_sent_q, words_sent_d;

  stream_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (fifo_rdata),
    .pop_i       (pop),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ_sum = occ + occ_t'(inflight_q);

  // A pop this cycle frees a slot, so reading with two words committed is still
  // safe; this is what keeps one word per cycle flowing under steady m_ready.
  assign fifo_rd = enable & ~fifo_empty & ((occ_sum < 2'd2) | pop);

  assign m_last     = (beat_q == BEAT_MAX);
  assign words_sent = words_sent_q;

  always_comb begin
    beat_d       = beat_q;
    words_sent_d = words_sent_q;
    if (pop) begin
      beat_d       = m_last ? '0 : beat_q + BEAT_W'(1);
      words_sent_d = words_sent_q + WORDS_SENT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      words_sent_q <= '0;
    end else begin
      inflight_q   <= fifo_rd;
      beat_q       <= beat_d;
      words_sent_q <= words_sent_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader with a FIFO model
module tb_fifo_stream_reader;

  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int DEPTH     = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      words_sent;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .words_sent (words_sent)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic [WIDTH-1:0] fq[$];
  beat_t            exp_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int exp_beat  = 0;
  int rd_count  = 0;
  int pop_count = 0;
  int loaded    = 0;

  logic             last_rd;
  logic             last_valid;
  logic             last_pop;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  // Stimulus side: word enters the FIFO model and its expected beat enters the scoreboard.
  task automatic load_word(input logic [WIDTH-1:0] w);
    beat_t b;
    fq.push_back(w);
    b.data = w;
    b.last = (exp_beat == BURST_LEN - 1);
    exp_q.push_back(b);
    exp_beat   = (exp_beat == BURST_LEN - 1) ? 0 : exp_beat + 1;
    loaded     = loaded + 1;
    fifo_empty = 1'b0;
  endtask

  // One clock: sample and check at the falling edge, then advance the FIFO model after the rise.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    cyc        = cyc + 1;
    last_rd    = fifo_rd;
    last_valid = m_valid;
    last_pop   = m_valid && m_ready;

    n_checks++;
    if (int'(dut.occ) + int'(dut.inflight_q) > 2) begin
      n_fail++;
      $display("FAIL occ_inflight cyc=%0d: got %0d, required <= 2", cyc,
               int'(dut.occ) + int'(dut.inflight_q));
    end
    n_checks++;
    if (fifo_rd === 1'b1 && fifo_empty === 1'b1) begin
      n_fail++;
      $display("FAIL rd_while_empty cyc=%0d: fifo_rd=1, required 0", cyc);
    end
    if (prev_stall) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d: valid=%b data=%h last=%b, required 1 %h %b",
                 cyc, m_valid, m_data, m_last, prev_data, prev_last);
      end
    end
    if (last_pop) begin
      pop_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat cyc=%0d: data=%h, required no beat", cyc, m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.data || m_last !== e.last) begin
          n_fail++;
          $display("FAIL beat cyc=%0d: data=%h last=%b, required %h %b",
                   cyc, m_data, m_last, e.data, e.last);
        end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (last_rd) rd_count++;

    @(posedge clk);
    #1;
    if (last_rd && fq.size() > 0) fifo_rdata = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    exp_beat   = 0;
    loaded     = 0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    prev_stall = 1'b0;
  endtask

  task automatic check_words_sent(input string name);
    n_checks++;
    if (words_sent !== 16'(loaded)) begin
      n_fail++;
      $display("FAIL %s_words_sent: got %0d, required %0d", name, words_sent, loaded);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    clear_model();
    @(negedge clk);
    n_checks++;
    if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0
        || words_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: rd=%b valid=%b data=%h last=%b sent=%0d, required 0 0 00 0 0",
               fifo_rd, m_valid, m_data, m_last, words_sent);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_stream();
    int first_rd = -1;
    int first_valid = -1;
    int last_pop_cyc = -1;
    int n = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int w = 1; w <= 8; w++) load_word(8'(w));
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
      if (last_rd && first_rd < 0) first_rd = cyc;
      if (last_valid && first_valid < 0) first_valid = cyc;
      if (last_pop) last_pop_cyc = cyc;
    end
    n_checks++;
    if (first_rd < 0 || first_valid - first_rd != 2) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d cycles, required 2", first_valid - first_rd);
    end
    n_checks++;
    if (exp_q.size() != 0 || last_pop_cyc - first_valid != 7) begin
      n_fail++;
      $display("FAIL stream_throughput: 8 beats over %0d cycles, required 8 (left %0d)",
               last_pop_cyc - first_valid + 1, exp_q.size());
    end
    check_words_sent("stream");
  endtask

  task automatic test_backpressure();
    int r0 = rd_count;
    m_ready = 1'b0;
    load_word(8'hA1);
    load_word(8'hA2);
    load_word(8'hA3);
    repeat (8) cycle();
    n_checks++;
    if (rd_count - r0 != 2) begin
      n_fail++;
      $display("FAIL bp_reads: got %0d fifo_rd pulses, required 2", rd_count - r0);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b data=%h, required 1 a1", m_valid, m_data);
    end
    m_ready = 1'b1;
    drain(20, "bp");
    check_words_sent("bp");
  endtask

  task automatic test_single();
    int r0 = rd_count;
    int p0 = pop_count;
    m_ready = 1'b1;
    load_word(8'h5C);
    drain(10, "single");
    repeat (3) cycle();
    n_checks++;
    if (rd_count - r0 != 1 || pop_count - p0 != 1) begin
      n_fail++;
      $display("FAIL single: reads=%0d beats=%0d, required 1 1", rd_count - r0, pop_count - p0);
    end
  endtask

  task automatic test_random();
    int p0 = pop_count;
    int to_load = 200;
    int n = 0;
    while ((to_load > 0 || exp_q.size() != 0) && n < 3000) begin
      if (to_load > 0 && fq.size() < DEPTH) begin
        load_word(8'($urandom));
        to_load--;
      end
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    n_checks++;
    if (to_load != 0 || exp_q.size() != 0 || pop_count - p0 != 200) begin
      n_fail++;
      $display("FAIL random: beats=%0d outstanding=%0d, required 200 0",
               pop_count - p0, exp_q.size() + to_load);
    end
    m_ready = 1'b1;
    check_words_sent("random");
  endtask

  task automatic test_enable_drop();
    int p0 = pop_count;
    int r1;
    m_ready = 1'b1;
    enable  = 1'b1;
    load_word(8'hE1);
    load_word(8'hE2);
    load_word(8'hE3);
    cycle();
    n_checks++;
    if (last_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL en_first_read: fifo_rd=%b, required 1", last_rd);
    end
    enable = 1'b0;
    r1 = rd_count;
    repeat (6) cycle();
    n_checks++;
    if (rd_count != r1 || pop_count - p0 != 1) begin
      n_fail++;
      $display("FAIL en_drop: reads=%0d beats=%0d, required 0 1", rd_count - r1, pop_count - p0);
    end
    enable = 1'b1;
    drain(20, "en");
    check_words_sent("en");
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    load_word(8'h11);
    load_word(8'h12);
    drain(10, "pre");
    m_ready = 1'b0;
    for (int w = 0; w < 4; w++) load_word(8'h21 + 8'(w));
    repeat (5) cycle();
    n_checks++;
    if (m_valid !== 1'b1 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_precondition: valid=%b last=%b, required 1 0", m_valid, m_last);
    end
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || words_sent !== 16'd0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b sent=%0d last=%b, required 0 0 0",
               m_valid, words_sent, m_last);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_ready = 1'b1;
    for (int w = 0; w < 4; w++) load_word(8'h31 + 8'(w));
    drain(20, "mid");
    check_words_sent("mid");
  endtask

  initial begin
    fifo_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_single();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
